bcd2_seg_scan: RTL
==================

Name: bcd2_seg_scan

Overview:
- Downstream display stage for the two-digit BCD counter: takes the tens and ones BCD digits and drives a time-multiplexed, two-digit common-anode/cathode 7-segment display.
- Snapshots both digits once per frame so the display never tears mid-frame.
- Inserts blanking gaps between digit slots to suppress ghosting.
- Optionally blanks a leading zero in the tens digit.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit per slot (>=1)
- BLANK_CYCLES, 16, dark cycles inserted before each digit slot (0 = no gap states)
- BLANK_LEAD_ZERO, 1, 1 = tens digit dark when its snapshot is 0
- ACTIVE_LOW, 1, 1 = seg and an outputs inverted at the pins (internal logic active-high)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- bcd_tens  input  4  tens digit from counter (bcd1)
- bcd_ones  input  4  ones digit from counter (bcd2)
- seg  output  7  segments {g,f,e,d,c,b,a}, registered
- an  output  2  digit enables, an[1]=tens, an[0]=ones, registered
- frame_tick  output  1  one-cycle pulse on each snapshot

Behaviour:
- Interface: single clock clk; reset rst is asynchronous, active-high.
- State machine: GAP_O -> SHOW_O -> GAP_T -> SHOW_T -> GAP_O.
  - GAP_x states last BLANK_CYCLES cycles each; SHOW_x states last REFRESH_DIV cycles each.
  - If BLANK_CYCLES=0, gap states are skipped: SHOW_T -> SHOW_O and SHOW_O -> SHOW_T directly.
  - Frame length = 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Slot counter: clears on every state transition; counts 0..len-1; advances state when count==len-1.
- Reset (async assert):
  - State=GAP_O (SHOW_O if BLANK_CYCLES=0); counter=0.
  - Snapshot regs=0, frame_tick=0.
  - Internal an=00, internal seg=0000000, so pins read all-inactive (1111111/11 when ACTIVE_LOW=1).
  - Reset release takes effect at the next clk edge; the first SHOW_O begins after BLANK_CYCLES cycles.
- Snapshot:
  - Taken on the edge entering SHOW_O: tens_q<=bcd_tens, ones_q<=bcd_ones, frame_tick=1 for exactly that cycle.
  - Input changes at any other time are ignored until the next snapshot.
  - With BLANK_CYCLES=0 and no gaps, the first snapshot is taken on the first edge after reset release.
- Outputs (registered, updated on the same edge the state is entered):
  - GAP_x: an=00, seg=0000000.
  - SHOW_O: an=01, seg=decode(ones_q).
  - SHOW_T: an=10, seg=decode(tens_q).
    - Exception: if BLANK_LEAD_ZERO=1 and tens_q==0, an=00 and seg=0000000.
- Decode (gfedcba, active-high):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10..15 (invalid BCD) = 1000000 (dash)
- Pin polarity: ACTIVE_LOW=1 inverts both seg and an at the output. frame_tick is never inverted.
- Exclusivity: at most one an bit is active in any cycle. Both bits active is a bug.
- Reset mid-frame: outputs go inactive immediately (asynchronous); snapshot is lost and the frame restarts from GAP_O.

Test Plan:
1. REFRESH_DIV=4, BLANK_CYCLES=2, ACTIVE_LOW=0; hold inputs 4/7; release reset.
   -> 2 dark cycles, then an=01 with seg=0000111 for 4 cycles, then 2 dark, then an=10 with seg=1100110 for 4 cycles.
   -> frame_tick high at cycles 2, 14, 26.
2. Same params; change inputs 4/7 -> 5/8 in the middle of SHOW_T.
   -> Current frame still shows 4 for tens.
   -> Next SHOW_O shows seg=1111111 (8); next SHOW_T shows 1101101 (5).
3. BLANK_LEAD_ZERO=1; inputs 0/3.
   -> SHOW_O: an=01, seg=1001111.
   -> SHOW_T: an=00, seg=0000000.
   -> Repeat with BLANK_LEAD_ZERO=0: SHOW_T shows an=10, seg=0111111.
4. Inputs 12/9.
   -> Tens slot shows seg=1000000 (dash); ones slot shows 1101111.
   -> Check an is never 11 across 100 frames.
5. BLANK_CYCLES=0, ACTIVE_LOW=1; inputs 9/9.
   -> No dark cycles; an alternates 10 (ones lit) / 01 (tens lit) every 4 cycles; seg pins=0010000.
6. Drive the upstream 00-99 counter into the block; assert rst asynchronously for 3 cycles mid-SHOW_O.
   -> seg/an go inactive in the same cycle, before the next clk edge.
   -> After release: BLANK_CYCLES dark cycles, then a fresh snapshot with frame_tick; displayed value matches the counter at that edge.

Source files
------------

// File: rtl/bcd2_seg_scan.sv
// Two-digit multiplexed 7-segment driver: snapshots the BCD pair once per frame,
// scans ones then tens with optional dark gaps, and optionally hides a leading zero.
module bcd2_seg_scan #(
  parameter int REFRESH_DIV     = 50000,
  parameter int BLANK_CYCLES    = 16,
  parameter int BLANK_LEAD_ZERO = 1,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int MAXLEN  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam bit HAS_GAP = (BLANK_CYCLES > 0);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = HAS_GAP ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    GAP_O  = 2'd0,
    SHOW_O = 2'd1,
    GAP_T  = 2'd2,
    SHOW_T = 2'd3
  } state_t;

  localparam state_t RESET_STATE = HAS_GAP ? GAP_O : SHOW_O;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [CW-1:0]   slot_last;
  logic            primed;
  logic            prime_edge;
  logic            enter_show_o;
  logic [3:0]      tens_q, ones_q, tens_next, ones_next;
  logic [6:0]      seg_int, seg_next;
  logic [1:0]      an_int, an_next;
  logic            tick_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // Without gaps the reset state is already SHOW_O, so the first edge after
  // release acts as the entry into SHOW_O (snapshot + counter restart).
  assign prime_edge = !primed && !HAS_GAP;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + 1'b1;
    slot_last    = (state == SHOW_O || state == SHOW_T) ? SHOW_LAST : GAP_LAST;
    enter_show_o = 1'b0;
    tens_next    = tens_q;
    ones_next    = ones_q;
    an_next      = 2'b00;
    seg_next     = 7'b0000000;
    tick_next    = 1'b0;

    if (prime_edge) begin
      state_next = SHOW_O;
    end else if (cnt == slot_last) begin
      case (state)
        GAP_O:   state_next = SHOW_O;
        SHOW_O:  state_next = HAS_GAP ? GAP_T : SHOW_T;
        GAP_T:   state_next = SHOW_T;
        default: state_next = HAS_GAP ? GAP_O : SHOW_O;
      endcase
    end

    if (state_next != state || prime_edge) begin
      cnt_next = '0;
    end

    enter_show_o = (state_next == SHOW_O) && (state != SHOW_O || prime_edge);
    if (enter_show_o) begin
      tens_next = bcd_tens;
      ones_next = bcd_ones;
      tick_next = 1'b1;
    end

    case (state_next)
      SHOW_O: begin
        an_next  = 2'b01;
        seg_next = decode(ones_next);
      end
      SHOW_T: begin
        if (!(BLANK_LEAD_ZERO != 0 && tens_next == 4'd0)) begin
          an_next  = 2'b10;
          seg_next = decode(tens_next);
        end
      end
      default: begin
        an_next  = 2'b00;
        seg_next = 7'b0000000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_STATE;
      cnt        <= '0;
      primed     <= 1'b0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      an_int     <= 2'b00;
      seg_int    <= 7'b0000000;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      primed     <= 1'b1;
      tens_q     <= tens_next;
      ones_q     <= ones_next;
      an_int     <= an_next;
      seg_int    <= seg_next;
      frame_tick <= tick_next;
    end
  end

  // Pin polarity applied after the registers so internal logic stays active-high.
  assign seg = (ACTIVE_LOW != 0) ? ~seg_int : seg_int;
  assign an  = (ACTIVE_LOW != 0) ? ~an_int  : an_int;

endmodule
